// File: rtl/game_fsm.sv
// Snake game supervisor: clear/idle/run/pause/fail/win sequencing, score and end-screen blink.
// Optional macro AUTO_RESTART_EN: FAIL/WIN fall back to CLEAR after 256 frame pulses.
module game_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_restart,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_vsync_pulse,
    input  logic       i_failure,
    input  logic       i_success,
    input  logic       i_eat,
    output logic       o_game_rst_n,
    output logic       o_run,
    output logic [2:0] o_state,
    output logic [7:0] o_score,
    output logic       o_blink
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_FAIL  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_clr_cnt;
    logic        r_pause_d;
    logic        r_eat_d;
    logic        r_game_rst_n;
    logic [7:0]  r_score;
    logic [4:0]  r_frame_cnt;
    logic        w_pause_edge;
    logic        w_eat_edge;
    logic        w_end_now;
    logic        w_end_next;
`ifdef AUTO_RESTART_EN
    logic [7:0]  r_auto_cnt;
    logic        w_timeout;
`endif

    assign w_pause_edge = i_pause & ~r_pause_d;
    assign w_eat_edge   = i_eat & ~r_eat_d;
    assign w_end_now    = (r_state == S_FAIL) || (r_state == S_WIN);
    assign w_end_next   = (w_next_state == S_FAIL) || (w_next_state == S_WIN);

`ifdef AUTO_RESTART_EN
    assign w_timeout = w_end_now && i_vsync_pulse && (r_auto_cnt == 8'd255);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_restart) begin
            w_next_state = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: if (r_clr_cnt == 2'd0) w_next_state = S_IDLE;
                S_IDLE:  if (i_start) w_next_state = S_RUN;
                S_RUN: begin
                    if (i_failure)         w_next_state = S_FAIL;
                    else if (i_success)    w_next_state = S_WIN;
                    else if (w_pause_edge) w_next_state = S_PAUSE;
                end
                S_PAUSE: if (w_pause_edge) w_next_state = S_RUN;
                S_FAIL, S_WIN: begin
`ifdef AUTO_RESTART_EN
                    if (w_timeout) w_next_state = S_CLEAR;
`else
                    w_next_state = r_state;
`endif
                end
                default: w_next_state = S_CLEAR;
            endcase
        end
    end

    // Counter idles at 3 outside CLEAR, so every entry into CLEAR starts a fresh 4-cycle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= 2'd3;
        end else if (i_restart || (r_state != S_CLEAR)) begin
            r_clr_cnt <= 2'd3;
        end else if (r_clr_cnt != 2'd0) begin
            r_clr_cnt <= r_clr_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause_d    <= 1'b0;
            r_eat_d      <= 1'b0;
            r_game_rst_n <= 1'b0;
        end else begin
            r_pause_d    <= i_pause;
            r_eat_d      <= i_eat;
            r_game_rst_n <= (w_next_state != S_CLEAR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= 8'd0;
        end else if (w_next_state == S_CLEAR) begin
            r_score <= 8'd0;
        end else if ((r_state == S_RUN) && w_eat_edge && (r_score != 8'd255)) begin
            r_score <= r_score + 8'd1;
        end
    end

    // Cleared on the entry and exit edges so the blink phase is 0 in every non-end state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 5'd0;
        end else if (!w_end_now || !w_end_next) begin
            r_frame_cnt <= 5'd0;
        end else if (i_vsync_pulse) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

`ifdef AUTO_RESTART_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= 8'd0;
        end else if (!w_end_now || !w_end_next) begin
            r_auto_cnt <= 8'd0;
        end else if (i_vsync_pulse) begin
            r_auto_cnt <= r_auto_cnt + 8'd1;
        end
    end
`endif

    assign o_state      = r_state;
    assign o_run        = (r_state == S_RUN);
    assign o_game_rst_n = r_game_rst_n;
    assign o_score      = r_score;
    assign o_blink      = r_frame_cnt[4];

endmodule
